// File: rtl/csa_serial_wide_adder.sv
// Serial wide adder: streams WIDTH-bit operands through one 4-bit carry-select
// adder a chunk per clock, LSB chunk first, chaining the carry between cycles.

module carry_select_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [2:0] lo;
   logic [2:0] hi0;
   logic [2:0] hi1;

   // Upper pair is computed for both possible carries and picked by the low carry.
   assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
   assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
   assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

   assign sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
   assign cout = lo[2] ? hi1[2] : hi0[2];

endmodule

module csa_serial_wide_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NCHUNK = WIDTH / 4;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
      $error("csa_serial_wide_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic [CW+1:0]    base;
   logic             last;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] partial_done;
   logic             carry_reg;
   logic [3:0]       csa_a;
   logic [3:0]       csa_b;
   logic [3:0]       csa_sum;
   logic             csa_cout;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and ready/valid are decoded from
   // state so input and output transfers can never coincide.

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   assign base  = {cnt, 2'b00};
   assign last  = (cnt == CW'(NCHUNK - 1));
   assign csa_a = a_reg[base +: 4];
   assign csa_b = b_reg[base +: 4];

   carry_select_adder u_csa (
      .a    (csa_a),
      .b    (csa_b),
      .cin  (carry_reg),
      .sum  (csa_sum),
      .cout (csa_cout)
   );

   // The top chunk is still in flight on the final RUN edge, so splice it in.
   always_comb begin
      partial_done = partial;
      partial_done[4*(NCHUNK-1) +: 4] = csa_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         partial   <= '0;
         carry_reg <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= cin;
                  cnt       <= '0;
               end
            end
            RUN: begin
               partial[base +: 4] <= csa_sum;
               carry_reg          <= csa_cout;
               if (last) begin
                  sum  <= partial_done;
                  cout <= csa_cout;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_ready && out_valid));

   a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout)));

endmodule

// File: tb/tb_csa_serial_wide_adder.sv
// Bench for csa_serial_wide_adder: directed WIDTH=16 scenarios plus randomized
// traffic on WIDTH=4/8/32 instances checked against plain a+b+cin arithmetic.

module tb_csa_serial_wide_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cur = 0;
   int wid [4] = '{16, 4, 8, 32};

   logic        in_valid_v  [4];
   logic        out_ready_v [4];
   logic        cin_v       [4];
   logic [31:0] a_v         [4];
   logic [31:0] b_v         [4];

   logic        rdy0, rdy1, rdy2, rdy3;
   logic        vld0, vld1, vld2, vld3;
   logic        co0, co1, co2, co3;
   logic [15:0] sum0;
   logic [3:0]  sum1;
   logic [7:0]  sum2;
   logic [31:0] sum3;

   logic        o_in_ready;
   logic        o_out_valid;
   logic        o_cout;
   logic [31:0] o_sum;

   logic [32:0] exp_q[$];

   csa_serial_wide_adder #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(rdy0),
      .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]), .out_valid(vld0),
      .out_ready(out_ready_v[0]), .sum(sum0), .cout(co0));

   csa_serial_wide_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(rdy1),
      .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]), .out_valid(vld1),
      .out_ready(out_ready_v[1]), .sum(sum1), .cout(co1));

   csa_serial_wide_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(rdy2),
      .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .out_valid(vld2),
      .out_ready(out_ready_v[2]), .sum(sum2), .cout(co2));

   csa_serial_wide_adder #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(rdy3),
      .a(a_v[3]), .b(b_v[3]), .cin(cin_v[3]), .out_valid(vld3),
      .out_ready(out_ready_v[3]), .sum(sum3), .cout(co3));

   // Observation mux: the instance under test is chosen by cur.
   always_comb begin
      o_in_ready  = rdy0;
      o_out_valid = vld0;
      o_sum       = {16'd0, sum0};
      o_cout      = co0;
      case (cur)
         1: begin o_in_ready = rdy1; o_out_valid = vld1; o_sum = {28'd0, sum1}; o_cout = co1; end
         2: begin o_in_ready = rdy2; o_out_valid = vld2; o_sum = {24'd0, sum2}; o_cout = co2; end
         3: begin o_in_ready = rdy3; o_out_valid = vld3; o_sum = sum3;          o_cout = co3; end
         default: begin end
      endcase
   end

   function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {32'd0, c};
   endfunction

   function automatic logic [31:0] mask_w(input int w);
      logic [32:0] m;
      m = (33'd1 << w) - 33'd1;
      return m[31:0];
   endfunction

   function automatic logic [32:0] observed(input int w);
      return {1'b0, o_sum} | ({32'd0, o_cout} << w);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic select(input int idx);
      cur = idx;
      #1;
   endtask

   task automatic accept_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                            input logic c, output bit ok, output int edges);
      bit acc;
      ok = 1'b0;
      edges = 0;
      in_valid_v[idx] = 1'b1;
      a_v[idx] = x;
      b_v[idx] = y;
      cin_v[idx] = c;
      while (!ok && edges < 20) begin
         acc = o_in_ready;
         step();
         edges++;
         if (acc) ok = 1'b1;
      end
      in_valid_v[idx] = 1'b0;
      a_v[idx] = $urandom;
      b_v[idx] = $urandom;
      cin_v[idx] = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!o_out_valid && cyc < 64) begin
         step();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid_v[i] = 1'b1;
         out_ready_v[i] = 1'b1;
         a_v[i] = $urandom;
         b_v[i] = $urandom;
         cin_v[i] = 1'b1;
      end
      repeat (3) step();
      for (int i = 0; i < 4; i++) begin
         select(i);
         checks++;
         if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_sum !== 32'd0 || o_cout !== 1'b0)
            begin errors++; $display("FAIL reset_w%0d: got vld=%b rdy=%b sum=%h cout=%b required 0 1 0 0",
                                    wid[i], o_out_valid, o_in_ready, o_sum, o_cout); end
      end
      for (int i = 0; i < 4; i++) in_valid_v[i] = 1'b0;
      rst_n = 1'b1;
      step();
      select(0);
      checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0)
         begin errors++; $display("FAIL reset_idle: got rdy=%b vld=%b required 1 0", o_in_ready, o_out_valid); end
   endtask

   task automatic test_basic();
      bit ok;
      int edges, cyc;
      select(0);
      out_ready_v[0] = 1'b1;
      accept_op(0, 32'h1234, 32'h1111, 1'b0, ok, edges);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_accept: got no acceptance required acceptance"); end
      wait_valid(cyc);
      checks++;
      if (cyc != 4) begin errors++; $display("FAIL basic_latency: got %0d edges required 4", cyc); end
      checks++;
      if (observed(16) !== model(32'h1234, 32'h1111, 1'b0))
         begin errors++; $display("FAIL basic_sum: got %h required %h", observed(16), model(32'h1234, 32'h1111, 1'b0)); end
      step();
      checks++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1)
         begin errors++; $display("FAIL basic_release: got vld=%b rdy=%b required 0 1", o_out_valid, o_in_ready); end
   endtask

   task automatic test_carry();
      logic [15:0] ta [3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
      logic [15:0] tb [3] = '{16'h0001, 16'h0000, 16'h8000};
      logic        tc [3] = '{1'b0, 1'b1, 1'b1};
      logic [16:0] te [3] = '{17'h1_0000, 17'h1_0000, 17'h1_0001};
      bit ok;
      int edges, cyc;
      select(0);
      out_ready_v[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         accept_op(0, {16'd0, ta[i]}, {16'd0, tb[i]}, tc[i], ok, edges);
         wait_valid(cyc);
         checks++;
         if (!ok || cyc != 4 || observed(16) !== {16'd0, te[i]})
            begin errors++; $display("FAIL carry_%0d: got ok=%0d lat=%0d result=%h required 1 4 %h",
                                     i, ok, cyc, observed(16), te[i]); end
         step();
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int edges, cyc;
      logic [32:0] held;
      select(0);
      out_ready_v[0] = 1'b0;
      accept_op(0, 32'hABCD, 32'h1357, 1'b1, ok, edges);
      wait_valid(cyc);
      held = model(32'hABCD, 32'h1357, 1'b1);
      checks++;
      if (!ok || cyc != 4 || observed(16) !== held)
         begin errors++; $display("FAIL bp_first: got ok=%0d lat=%0d result=%h required 1 4 %h", ok, cyc, observed(16), held); end
      for (int i = 0; i < 6; i++) begin
         in_valid_v[0] = 1'b1;
         a_v[0] = {16'd0, 16'($urandom)};
         b_v[0] = {16'd0, 16'($urandom)};
         cin_v[0] = 1'($urandom_range(0, 1));
         step();
         checks++;
         if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || observed(16) !== held)
            begin errors++; $display("FAIL bp_hold_%0d: got vld=%b rdy=%b result=%h required 1 0 %h",
                                     i, o_out_valid, o_in_ready, observed(16), held); end
      end
      a_v[0] = 32'h0000_7777;
      b_v[0] = 32'h0000_9999;
      cin_v[0] = 1'b0;
      out_ready_v[0] = 1'b1;
      step();
      checks++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || observed(16) !== held)
         begin errors++; $display("FAIL bp_release: got vld=%b rdy=%b result=%h required 0 1 %h",
                                  o_out_valid, o_in_ready, observed(16), held); end
      accept_op(0, 32'h0000_7777, 32'h0000_9999, 1'b0, ok, edges);
      checks++;
      if (!ok || edges != 1) begin errors++; $display("FAIL bp_reaccept: got ok=%0d edges=%0d required 1 1", ok, edges); end
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || observed(16) !== model(32'h7777, 32'h9999, 1'b0))
         begin errors++; $display("FAIL bp_second: got lat=%0d result=%h required 4 %h",
                                  cyc, observed(16), model(32'h7777, 32'h9999, 1'b0)); end
      step();
   endtask

   task automatic test_abort();
      bit ok;
      int edges, cyc;
      bit seen;
      select(0);
      out_ready_v[0] = 1'b1;
      accept_op(0, 32'h5555, 32'h3333, 1'b0, ok, edges);
      step();
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_sum !== 32'd0 || o_cout !== 1'b0)
         begin errors++; $display("FAIL abort_reset: got vld=%b rdy=%b sum=%h cout=%b required 0 1 0 0",
                                  o_out_valid, o_in_ready, o_sum, o_cout); end
      step();
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (o_out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_no_result: got out_valid=1 required 0"); end
      accept_op(0, 32'h0F0F, 32'h00F1, 1'b0, ok, edges);
      wait_valid(cyc);
      checks++;
      if (!ok || cyc != 4 || observed(16) !== 33'h0_1000)
         begin errors++; $display("FAIL abort_fresh: got ok=%0d lat=%0d result=%h required 1 4 01000",
                                  ok, cyc, observed(16)); end
      step();
   endtask

   task automatic test_random(input int idx, input int n);
      int w, nchunk, delivered, k, gap, edges;
      bit ok, done, hs;
      logic [31:0] m, x, y;
      logic c;
      logic [32:0] exp_v;
      w = wid[idx];
      nchunk = w / 4;
      m = mask_w(w);
      delivered = 0;
      select(idx);
      for (int t = 0; t < n; t++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            out_ready_v[idx] = 1'($urandom_range(0, 1));
            a_v[idx] = $urandom;
            step();
         end
         x = $urandom & m;
         y = $urandom & m;
         c = 1'($urandom_range(0, 1));
         out_ready_v[idx] = 1'($urandom_range(0, 1));
         accept_op(idx, x, y, c, ok, edges);
         checks++;
         if (!ok) begin errors++; $display("FAIL rand_w%0d_accept: got no acceptance required acceptance", w); end
         exp_q.push_back(model(x, y, c));
         k = 0;
         done = 1'b0;
         while (!done && k < nchunk + 64) begin
            out_ready_v[idx] = ($urandom_range(0, 2) != 0);
            hs = o_out_valid && out_ready_v[idx];
            if (hs) begin
               exp_v = exp_q.pop_front();
               checks++;
               if (observed(w) !== exp_v)
                  begin errors++; $display("FAIL rand_w%0d_sum: got %h required %h (a=%h b=%h cin=%b)",
                                           w, observed(w), exp_v, x, y, c); end
            end
            step();
            k++;
            if (k <= nchunk) begin
               checks++;
               if (o_out_valid !== (k == nchunk))
                  begin errors++; $display("FAIL rand_w%0d_latency: edge %0d got out_valid=%b required %b",
                                           w, k, o_out_valid, (k == nchunk)); end
            end
            if (hs) begin
               done = 1'b1;
               delivered++;
               checks++;
               if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1)
                  begin errors++; $display("FAIL rand_w%0d_once: got vld=%b rdy=%b required 0 1",
                                           w, o_out_valid, o_in_ready); end
            end
         end
         if (!done) begin
            checks++;
            errors++;
            $display("FAIL rand_w%0d_timeout: got no result after %0d edges required one", w, k);
            void'(exp_q.pop_front());
         end
      end
      checks++;
      if (delivered != n || exp_q.size() != 0)
         begin errors++; $display("FAIL rand_w%0d_count: got %0d delivered %0d pending required %0d 0",
                                  w, delivered, exp_q.size(), n); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         in_valid_v[i] = 1'b0;
         out_ready_v[i] = 1'b0;
         a_v[i] = '0;
         b_v[i] = '0;
         cin_v[i] = 1'b0;
      end
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_abort();
      test_random(1, 500);
      test_random(2, 500);
      test_random(3, 500);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
